// File: rtl/keyboard_input.sv
// Keyboard input controller: buffers received characters in a 4-deep FIFO
// and presents them to the CPU through a status register (KBSR) and a data
// register (KBDR). A three-state read FSM consumes one character per KBDR read.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a KBDR read; ready shown when FIFO not empty
//   ST_POP    | one cycle: o_pop asserted, read pointer advances, count drops
//   ST_SETTLE | one cycle: ready held low so the CPU sees the pop complete
module keyboard_input (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_kbdr_rd,
  input  logic        i_kbsr_wr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_kbsr,
  output logic [15:0] o_kbdr,
  output logic        o_intr,
  output logic        o_pop
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        ie;
  logic        overrun;

  logic        fifo_empty;
  logic        fifo_full;
  logic        pop_en;
  logic        push_en;
  logic        ovf_set;
  logic        ready;
  logic [7:0]  head_byte;
  logic        wdata_unused;

  assign fifo_empty = (count == 3'd0);
  assign fifo_full  = (count == 3'd4);

  // A push at full is still accepted when a pop frees a slot on the same edge.
  assign push_en = i_rx_valid && (!fifo_full || pop_en);
  assign ovf_set = i_rx_valid && fifo_full && !pop_en;

  // Read FSM next-state and pop strobe.
  always_comb begin
    state_nxt = state;
    pop_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_kbdr_rd && !fifo_empty) begin
          state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        pop_en    = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge i_Clk) begin
    if (push_en) begin
      fifo_mem[wr_ptr] <= i_rx_data;
    end
  end

  // Interrupt enable and sticky overrun; a new overflow outranks a clear.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ie      <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (i_kbsr_wr) begin
        ie <= i_wdata[14];
      end
      if (ovf_set) begin
        overrun <= 1'b1;
      end else if (i_kbsr_wr && i_wdata[13]) begin
        overrun <= 1'b0;
      end
    end
  end

  // Only IE and the overrun-clear bit of a KBSR write are meaningful.
  assign wdata_unused = ^{i_wdata[15], i_wdata[12:0]};

  assign ready     = (state == ST_IDLE) && !fifo_empty;
  assign head_byte = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  assign o_kbsr = {ready, ie, overrun, 13'd0};
  assign o_kbdr = {8'h00, head_byte};
  assign o_intr = ready & ie;
  assign o_pop  = pop_en;

endmodule

// File: tb/tb_keyboard_input.sv
// Directed bench for keyboard_input: characters are pushed into a scoreboard
// queue as they are sent and compared against KBDR when o_pop marks them consumed.
module tb_keyboard_input;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        i_kbdr_rd;
  logic        i_kbsr_wr;
  logic [15:0] i_wdata;
  logic [15:0] o_kbsr;
  logic [15:0] o_kbdr;
  logic        o_intr;
  logic        o_pop;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q [$];

  keyboard_input dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_rx_valid (i_rx_valid),
    .i_rx_data  (i_rx_data),
    .i_kbdr_rd  (i_kbdr_rd),
    .i_kbsr_wr  (i_kbsr_wr),
    .i_wdata    (i_wdata),
    .o_kbsr     (o_kbsr),
    .o_kbdr     (o_kbdr),
    .o_intr     (o_intr),
    .o_pop      (o_pop)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit stored);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    if (stored) exp_q.push_back(b);
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic kbsr_write(input logic [15:0] w);
    i_kbsr_wr = 1'b1;
    i_wdata   = w;
    tick();
    i_kbsr_wr = 1'b0;
  endtask

  task automatic read_char(input string tag);
    logic [7:0] e;
    int waited;
    waited = 0;
    i_kbdr_rd = 1'b1;
    tick();
    i_kbdr_rd = 1'b0;
    while (o_pop !== 1'b1 && waited < 3) begin
      tick();
      waited++;
    end
    chk({tag, "_pop"}, 16'(o_pop), 16'h0001);
    if (o_pop === 1'b1) begin
      chk({tag, "_sb_underflow"}, 16'(exp_q.size() == 0), 16'h0000);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk({tag, "_data"}, o_kbdr, {8'h00, e});
      chk({tag, "_rdy_in_pop"}, 16'(o_kbsr[15]), 16'h0000);
      chk({tag, "_intr_in_pop"}, 16'(o_intr), 16'h0000);
      tick();
      chk({tag, "_pop_settle"}, 16'(o_pop), 16'h0000);
      chk({tag, "_rdy_settle"}, 16'(o_kbsr[15]), 16'h0000);
      chk({tag, "_intr_settle"}, 16'(o_intr), 16'h0000);
      tick();
    end
  endtask

  task automatic read_ignored(input string tag);
    i_kbdr_rd = 1'b1;
    tick();
    i_kbdr_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_no_pop"}, 16'(o_pop), 16'h0000);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_Rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_kbdr_rd  = 1'b0;
    i_kbsr_wr  = 1'b0;
    i_wdata    = 16'h0000;
    #1;
    chk("rst_kbsr", o_kbsr, 16'h0000);
    chk("rst_kbdr", o_kbdr, 16'h0000);
    chk("rst_intr", 16'(o_intr), 16'h0000);
    chk("rst_pop", 16'(o_pop), 16'h0000);
    #23;
    i_Rst_n = 1'b1;
    tick();
    chk("post_rst_kbsr", o_kbsr, 16'h0000);

    // Single character
    push(8'h41, 1'b1);
    chk("single_kbsr", o_kbsr, 16'h8000);
    chk("single_kbdr", o_kbdr, 16'h0041);
    chk("single_intr", 16'(o_intr), 16'h0000);
    read_char("single");
    chk("single_after_kbsr", o_kbsr, 16'h0000);
    chk("single_after_kbdr", o_kbdr, 16'h0000);

    // Fill and overflow: 0x35 is dropped
    push(8'h31, 1'b1);
    push(8'h32, 1'b1);
    push(8'h33, 1'b1);
    push(8'h34, 1'b1);
    chk("fill4_kbsr", o_kbsr, 16'h8000);
    push(8'h35, 1'b0);
    chk("ovf_kbsr", o_kbsr, 16'hA000);
    chk("ovf_kbdr", o_kbdr, 16'h0031);
    for (int i = 0; i < 4; i++) read_char("fill");
    chk("fill_drained_kbsr", o_kbsr, 16'h2000);
    read_ignored("empty_rd");

    // Interrupt enable, interrupt during pop, then clear overrun and IE
    kbsr_write(16'h4000);
    chk("ie_kbsr", o_kbsr, 16'h6000);
    chk("ie_no_intr", 16'(o_intr), 16'h0000);
    push(8'h0A, 1'b1);
    chk("intr_kbsr", o_kbsr, 16'hE000);
    chk("intr_on", 16'(o_intr), 16'h0001);
    read_char("intr");
    chk("intr_after_kbsr", o_kbsr, 16'h6000);
    kbsr_write(16'h2000);
    chk("clr_kbsr", o_kbsr, 16'h0000);

    // Pointer wrap across 3 -> 0
    for (int i = 0; i < 6; i++) begin
      push(8'h61 + 8'(i), 1'b1);
      read_char("wrap");
    end
    push(8'h51, 1'b1);
    push(8'h52, 1'b1);
    push(8'h53, 1'b1);
    read_char("wrap3");
    read_char("wrap3");
    read_char("wrap3");

    // Push landing on the POP edge while full
    push(8'h71, 1'b1);
    push(8'h72, 1'b1);
    push(8'h73, 1'b1);
    push(8'h74, 1'b1);
    i_kbdr_rd = 1'b1;
    tick();
    i_kbdr_rd = 1'b0;
    chk("sim_pop", 16'(o_pop), 16'h0001);
    chk("sim_data", o_kbdr, {8'h00, exp_q.pop_front()});
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h75;
    exp_q.push_back(8'h75);
    tick();
    i_rx_valid = 1'b0;
    chk("sim_no_ovf", 16'(o_kbsr[13]), 16'h0000);
    tick();
    chk("sim_full_kbsr", o_kbsr, 16'h8000);
    for (int i = 0; i < 4; i++) read_char("sim");
    chk("sim_drained_kbsr", o_kbsr, 16'h0000);

    // Overflow and overrun-clear write on the same edge: overrun stays set
    push(8'hB1, 1'b1);
    push(8'hB2, 1'b1);
    push(8'hB3, 1'b1);
    push(8'hB4, 1'b1);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hB5;
    i_kbsr_wr  = 1'b1;
    i_wdata    = 16'h2000;
    tick();
    i_rx_valid = 1'b0;
    i_kbsr_wr  = 1'b0;
    chk("setwins_kbsr", o_kbsr, 16'hA000);
    kbsr_write(16'h2000);
    chk("setwins_clr_kbsr", o_kbsr, 16'h8000);
    for (int i = 0; i < 4; i++) read_char("setwins");

    // Reset asserted during POP with three characters buffered
    push(8'h91, 1'b1);
    push(8'h92, 1'b1);
    push(8'h93, 1'b1);
    i_kbdr_rd = 1'b1;
    tick();
    i_kbdr_rd = 1'b0;
    chk("rstpop_in_pop", 16'(o_pop), 16'h0001);
    i_Rst_n = 1'b0;
    #1;
    chk("rstpop_kbsr", o_kbsr, 16'h0000);
    chk("rstpop_kbdr", o_kbdr, 16'h0000);
    chk("rstpop_intr", 16'(o_intr), 16'h0000);
    chk("rstpop_pop", 16'(o_pop), 16'h0000);
    exp_q.delete();
    #2;
    i_Rst_n = 1'b1;
    tick();
    chk("rstpop_after_kbsr", o_kbsr, 16'h0000);
    chk("rstpop_after_kbdr", o_kbdr, 16'h0000);
    read_ignored("rstpop_rd");
    push(8'hA5, 1'b1);
    chk("rstpop_new_kbsr", o_kbsr, 16'h8000);
    chk("rstpop_new_kbdr", o_kbdr, 16'h00A5);
    read_char("rstpop_new");
    chk("final_kbsr", o_kbsr, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_input.md
KEYBOARD_INPUT -- requirements
Module: keyboard_input

Interface
REQ-001 The block SHALL have one clock and one reset: the reset SHALL be asynchronous and active-low.
REQ-002 i_Clk  input  1  the only clock; all state changes occur on its rising edge.
REQ-003 i_Rst_n  input  1  asynchronous active-low reset.
REQ-004 i_rx_valid  input  1  one-cycle strobe: a received character is present on i_rx_data.
REQ-005 i_rx_data  input  8  received ASCII character, sampled when i_rx_valid=1.
REQ-006 i_kbdr_rd  input  1  one-cycle strobe: the CPU reads KBDR.
REQ-007 i_kbsr_wr  input  1  one-cycle strobe: the CPU writes KBSR.
REQ-008 i_wdata  input  16  CPU write data, sampled when i_kbsr_wr=1.
REQ-009 o_kbsr  output  16  keyboard status register: [15]=ready, [14]=interrupt enable (IE), [13]=overrun, [12:0]=0.
REQ-010 o_kbdr  output  16  keyboard data register: {8'h00, FIFO head byte}; 16'h0000 when the FIFO is empty.
REQ-011 o_intr  output  1  interrupt request, equal to KBSR[15] & KBSR[14].
REQ-012 o_pop  output  1  one-cycle pulse marking each consumed character.

Function
REQ-013 The block SHALL buffer received characters in a 4-entry, 8-bit FIFO with 2-bit read/write pointers that wrap from 3 to 0, and a 3-bit count (0..4).
REQ-014 On an edge where i_rx_valid=1 and count<4, the block SHALL write i_rx_data at the write pointer, increment the write pointer and increment count.
REQ-015 On an edge where i_rx_valid=1 and count=4 with no pop on that edge, the block SHALL drop the character and set overrun (KBSR[13]).
REQ-016 Overrun SHALL be sticky; it SHALL clear only on reset or on a KBSR write with i_wdata[13]=1.
REQ-017 A KBSR write SHALL load IE from i_wdata[14]; bits [15] and [12:0] of i_wdata SHALL be ignored.
REQ-018 The read FSM SHALL have three states: IDLE, POP and SETTLE. Reset state is IDLE.
REQ-019 In IDLE, when i_kbdr_rd=1 and count>0, the FSM SHALL go to POP; otherwise it SHALL stay in IDLE.
REQ-020 POP SHALL last one cycle: assert o_pop=1, increment the read pointer, decrement count, then go to SETTLE.
REQ-021 SETTLE SHALL last one cycle and then return to IDLE; o_pop=0 in SETTLE.
REQ-022 i_kbdr_rd SHALL be ignored in POP and SETTLE, and in IDLE when count=0; no pointer or count change results.
REQ-023 KBSR[15] SHALL be 1 only when the state is IDLE and count>0; it is forced to 0 in POP and SETTLE.
REQ-024 o_kbdr SHALL show the byte at the read pointer, registered: a character pushed into an empty FIFO at edge N is visible, with KBSR[15]=1, after edge N.
REQ-025 If a push (i_rx_valid=1) and the POP decrement occur on the same edge, both SHALL take effect:
  - count is unchanged;
  - when count=4, no overrun is set and the character is stored.
REQ-026 A KBSR write and a push on the same edge SHALL both take effect; a push that overflows on the same edge as a write with i_wdata[13]=1 SHALL leave overrun set (set wins).
REQ-027 o_intr SHALL be registered-equivalent: derived combinationally only from registered KBSR bits, with no combinational path from any input.

Reset
REQ-028 While i_Rst_n=0, independent of i_Clk:
  - FSM in IDLE; pointers and count = 0;
  - IE = 0; overrun = 0;
  - o_kbsr=16'h0000, o_kbdr=16'h0000, o_intr=0, o_pop=0.
REQ-029 Reset asserted mid-POP or mid-SETTLE SHALL discard all buffered characters; FIFO storage contents need not be cleared.
REQ-030 After i_Rst_n deasserts, the first state change SHALL occur on the next rising edge of i_Clk.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
  - Single char: push 8'h41, then i_kbdr_rd → after push, o_kbsr=16'h8000 and o_kbdr=16'h0041; o_pop pulses 1 cycle after the read; o_kbsr=16'h0000 thereafter.
  - Fill/overflow: push 0x31, 0x32, 0x33, 0x34, 0x35 → count=4, o_kbsr=16'hA000; four reads return 0x31..0x34 in order, each 3 cycles apart; 0x35 is lost.
  - Pointer wrap: push and pop 6 characters → read order matches write order across the 3→0 wrap.
  - Simultaneous push+pop at full: push lands on the POP edge → no overrun; the new byte is read fifth.
  - Interrupt: write i_wdata=16'h4000, then push 8'h0A → o_intr=1; o_intr drops during POP/SETTLE; write 16'h2000 clears overrun and IE → o_kbsr[14:13]=0.
  - Reset mid-POP: assert i_Rst_n=0 during POP with count=3 → all outputs 0 immediately; after release, reads are ignored until a new push.
